bcd_addsub_seq: RTL and testbench
=================================

// Module: bcd_addsub_seq
// PURPOSE
//  Multi-digit packed-BCD adder/subtractor, digit-serial (one BCD digit per clock, LSD first).
//  Successor to the single-digit combinational BCD subtractor:
//   - parametrised digit count;
//   - add and subtract modes;
//   - signed-magnitude subtract result (10's-complement fix-up pass when negative);
//   - valid/ready handshakes on input and output.
//  Sits between operand registers and the BCD display/accumulate path.
// PARAMETERS
//  DIGITS   4   number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         operands + op_sub valid
//  in_ready   out  1         block can accept operands (high only in IDLE)
//  op_sub     in   1         0: a+b, 1: a-b
//  a          in   4*DIGITS  packed BCD operand A, digit 0 in [3:0]
//  b          in   4*DIGITS  packed BCD operand B
//  out_valid  out  1         result valid; held until out_ready
//  out_ready  in   1         downstream accepts result
//  result     out  4*DIGITS  packed BCD magnitude
//  cout       out  1         add: decimal carry out of MSD (overflow); sub: always 0
//  neg        out  1         sub: result negative (a<b); add: always 0
//  err        out  1         (BCD_CHECK_EN only) some input digit >9
// BEHAVIOUR
//  Reset (async): FSM=IDLE; in_ready=1; out_valid=0; result=0; cout=0; neg=0; err=0; digit ctr=0.
//  FSM:
//   IDLE  in_valid&&in_ready -> latch a, b, op_sub -> CALC; carry := op_sub (the +1 of 10's complement)
//   CALC  per cycle, digit i = ctr:
//         bi' = op_sub ? 9-b_i : b_i;  t = a_i + bi' + carry (5 bits)
//         t>9 -> digit = t+6 [3:0], carry=1; else digit = t[3:0], carry=0
//         ctr==DIGITS-1 ->
//           add:           cout=carry; neg=0 -> DONE
//           sub, carry=1:  neg=0 -> DONE
//           sub, carry=0:  neg=1; carry:=1 -> FIX (result is 10's complement of |a-b|)
//   FIX   per cycle: digit_i = (9 - digit_i) + carry with the same >9 / +6 correction;
//         after DIGITS cycles -> DONE (final carry discarded)
//   DONE  out_valid=1; result/cout/neg stable; out_ready -> IDLE, out_valid=0 next cycle
//  Latency, handshake edge to out_valid high:
//   DIGITS+1 cycles (add, or sub with a>=b); 2*DIGITS+1 cycles (sub with a<b).
//  Counter: ctr wraps to 0 on entering FIX and on entering DONE.
//  in_ready=0 outside IDLE; in_valid then ignored (no queuing).
//  No same-cycle accept after DONE: earliest next accept is the cycle after the out_ready handshake.
//  out_valid && !out_ready -> hold indefinitely, no corruption.
//  a==b subtract -> result 0, neg=0 (never "-0").
//  Invalid BCD input digits (>9) without the macro: result undefined, FSM timing unchanged.
//  rst mid-CALC/FIX/DONE -> immediate return to IDLE with reset values; partial result discarded.
// CONFIGURATION
//  BCD_CHECK_EN defined:
//   - err port present; all input digits checked at acceptance.
//   - Any digit >9 -> err=1, result=0, cout=0, neg=0, straight to DONE
//     (out_valid 1 cycle after the handshake).
//   - err cleared on the next accept or on rst.
//  BCD_CHECK_EN undefined: err port absent, no checking logic.
// TESTING (DIGITS=4)
//  add 1234+5678              -> result 6912, cout=0, neg=0, out_valid 5 cycles after accept
//  add 9999+0001              -> result 0000, cout=1
//  sub 5000-1234              -> result 3766, neg=0, latency 5
//  sub 1234-5000              -> result 3766, neg=1, latency 9
//  sub 0042-0042              -> result 0000, neg=0
//  out_ready low 10 cycles    -> out_valid/result stable, in_ready=0
//  rst asserted during FIX    -> out_valid=0 and in_ready=1 immediately
//  BCD_CHECK_EN: a=12A4       -> err=1, result 0000 after 1 cycle

Source files
------------

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, signed-magnitude subtract result.
// Optional input digit checking with `define BCD_CHECK_EN (adds the err port).
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
`ifdef BCD_CHECK_EN
    output logic                  err,
`endif
    output logic                  neg
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  a_reg, b_reg;
    logic          sub_reg, carry;
    logic [CW-1:0] ctr;
    logic [4:0]    calc_sum, fix_sum;
    logic [W-1:0]  res_calc, res_fix;
    logic          accept, last, bad_in;

    // One decimal digit step: {carry, digit} with the +6 correction above 9.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [4:0] t;
        logic [4:0] t6;
        t  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        t6 = t + 5'd6;
        if (t > 5'd9) return {1'b1, t6[3:0]};
        else          return {1'b0, t[3:0]};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (ctr == LAST);

`ifdef BCD_CHECK_EN
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
        end
    end
`else
    assign bad_in = 1'b0;
`endif

    always_comb begin
        calc_sum = digit_add(a_reg[3:0], sub_reg ? (4'd9 - b_reg[3:0]) : b_reg[3:0], carry);
        fix_sum  = digit_add(4'd9 - result[3:0], 4'd0, carry);
        // Result shifts right; each new digit enters at the MSD position.
        res_calc = result >> 4;
        res_calc[W-1 -: 4] = calc_sum[3:0];
        res_fix  = result >> 4;
        res_fix[W-1 -: 4]  = fix_sum[3:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = bad_in ? DONE : CALC;
            CALC: if (last)   state_nxt = (!sub_reg || calc_sum[4]) ? DONE : FIX;
            FIX:  if (last)   state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            ctr     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            neg     <= 1'b0;
`ifdef BCD_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_reg   <= a;
                    b_reg   <= b;
                    sub_reg <= op_sub;
                    carry   <= op_sub;
                    ctr     <= '0;
                    result  <= '0;
                    cout    <= 1'b0;
                    neg     <= 1'b0;
`ifdef BCD_CHECK_EN
                    err     <= bad_in;
`endif
                end
                CALC: begin
                    a_reg  <= a_reg >> 4;
                    b_reg  <= b_reg >> 4;
                    result <= res_calc;
                    carry  <= calc_sum[4];
                    if (last) begin
                        ctr <= '0;
                        if (!sub_reg) begin
                            cout <= calc_sum[4];
                        end else if (!calc_sum[4]) begin
                            neg   <= 1'b1;
                            carry <= 1'b1;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                FIX: begin
                    result <= res_fix;
                    carry  <= fix_sum[4];
                    ctr    <= last ? '0 : ctr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed test of bcd_addsub_seq (DIGITS=4): arithmetic, latency, hold, reset, optional err.
module tb_bcd_addsub_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        cout;
    logic        neg;
`ifdef BCD_CHECK_EN
    logic        err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bcd_addsub_seq #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
`ifdef BCD_CHECK_EN
        .err       (err),
`endif
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check the result and accept-to-out_valid latency
    // (latency counts edges starting with the accepting edge).
    task automatic run_op(input string tag, input logic sub, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er, input logic ec,
                          input logic en, input int el);
        int n;
        @(negedge clk);
        op_sub = sub; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(el));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_neg"}, 32'(neg), 32'(en));
`ifdef BCD_CHECK_EN
        check({tag, "_err"}, 32'(err), 32'd0);
`endif
        @(posedge clk); #1;
        check({tag, "_release"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
`ifdef BCD_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 5);
        run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 5);
        run_op("add_9999_9999", 1'b0, 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 5);
        run_op("add_0000_0000", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5);
        run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 5);
        run_op("sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 9);
        run_op("sub_0042_0042", 1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b0, 1'b0, 5);
        run_op("sub_0000_0001", 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 9);
        run_op("sub_9999_0000", 1'b1, 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5);

        // Backpressure: result must hold while out_ready is low; new requests ignored.
        @(negedge clk);
        op_sub = 1'b0; a = 16'h0815; b = 16'h0185; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; op_sub = 1'b1;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_latency", 32'(n), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'h1000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release", 32'(out_valid), 32'd0);
        check("hold_idle", 32'(in_ready), 32'd1);

        // Reset while in the fix-up pass of a negative subtract.
        @(negedge clk);
        op_sub = 1'b1; a = 16'h1234; b = 16'h5000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("fix_not_done", 32'(out_valid), 32'd0);
        check("fix_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_fix_out_valid", 32'(out_valid), 32'd0);
        check("rst_fix_in_ready", 32'(in_ready), 32'd1);
        check("rst_fix_result", 32'(result), 32'd0);
        check("rst_fix_neg", 32'(neg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("after_rst_add", 1'b0, 16'h0500, 16'h0499, 16'h0999, 1'b0, 1'b0, 5);

`ifdef BCD_CHECK_EN
        @(negedge clk);
        op_sub = 1'b0; a = 16'h12A4; b = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("err_out_valid", 32'(out_valid), 32'd1);
        check("err_flag", 32'(err), 32'd1);
        check("err_result", 32'(result), 32'd0);
        check("err_cout", 32'(cout), 32'd0);
        check("err_neg", 32'(neg), 32'd0);
        @(posedge clk); #1;
        check("err_release", 32'(out_valid), 32'd0);
        run_op("err_clear", 1'b1, 16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
